// File: rtl/tb_mem_mmio_split_if.sv
// One-cycle memory port bundle: request fields travel master->slave, read data returns
// one cycle after a read request.
interface tb_mem_mmio_split_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;

    modport master (output req, we, addr, be, wdata, input rdata);
    modport slave  (input req, we, addr, be, wdata, output rdata);
endinterface

// File: rtl/tb_mem_mmio_split.sv
// Splits a one-cycle memory port between the testbench SRAM and a 4 KiB MMIO register window
// (EXIT, CONSOLE_TX, STATUS, SCRATCH). Define TB_MMIO_CONSOLE_EN to build the console FIFO.
module tb_mem_mmio_split #(
    parameter int          ADDR_WIDTH    = 64,
    parameter int          DATA_WIDTH    = 64,
    parameter logic [63:0] MMIO_BASE     = 64'h0000_0000_1100_0000,
    parameter int          CONSOLE_DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    tb_mem_mmio_split_if.slave         up,
    tb_mem_mmio_split_if.master        mem,
    output logic                       exit_valid_o,
    output logic [31:0]                exit_code_o,
    output logic                       cons_valid_o,
    output logic [7:0]                 cons_data_o,
    input  logic                       cons_ready_i
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [8:0] SEL_EXIT    = 9'd0;
    localparam logic [8:0] SEL_CONS    = 9'd1;
    localparam logic [8:0] SEL_STATUS  = 9'd2;
    localparam logic [8:0] SEL_SCRATCH = 9'd3;

    logic              hit;
    logic [8:0]        sel;
    logic              wr_hit;
    logic              rd_req;
    logic [NBYTES-1:0] scratch_we;
    logic [DATA_WIDTH-1:0] reg_val;
    logic [DATA_WIDTH-1:0] status_val;

    logic                  exit_valid_q, exit_valid_d;
    logic [31:0]           exit_code_q, exit_code_d;
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] mmio_rdata_q, mmio_rdata_d;

    // Low address bits only pick a byte inside a 64-bit register and carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^up.addr[2:0];

    assign hit    = (up.addr[ADDR_WIDTH-1:12] == MMIO_BASE[ADDR_WIDTH-1:12]);
    assign sel    = up.addr[11:3];
    assign wr_hit = up.req & up.we & hit;
    assign rd_req = up.req & ~up.we;

    assign mem.req   = up.req & ~hit;
    assign mem.we    = up.we;
    assign mem.addr  = up.addr;
    assign mem.be    = up.be;
    assign mem.wdata = up.wdata;
    assign up.rdata  = sel_q ? mmio_rdata_q : mem.rdata;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_scratch_lane
        assign scratch_we[gi] = wr_hit & (sel == SEL_SCRATCH) & up.be[gi];
    end

`ifdef TB_MMIO_CONSOLE_EN
    localparam int PTR_W = $clog2(CONSOLE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       fifo_mem_q [CONSOLE_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [7:0]       cons_data_q, cons_data_d;
    logic             push_req, push_ok, pop, full, empty;

    assign full     = (count_q == CNT_W'(CONSOLE_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = ~empty & cons_ready_i;
    assign push_req = wr_hit & (sel == SEL_CONS) & up.be[0];
    // A pop frees the slot this very cycle, so a push into a full FIFO is still accepted.
    assign push_ok  = push_req & (~full | pop);

    always_comb begin
        wptr_d      = wptr_q + PTR_W'(push_ok);
        rptr_d      = rptr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        drop_cnt_d  = drop_cnt_q;
        if (push_req && full && !pop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
        cons_data_d = 8'h00;
        // The new head may be the byte being written right now, which the array does not hold yet.
        if (count_d != '0) begin
            if (push_ok && wptr_q == rptr_d)
                cons_data_d = up.wdata[7:0];
            else
                cons_data_d = fifo_mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i)
            fifo_mem_q[wptr_q] <= up.wdata[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            cons_data_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            cons_data_q <= cons_data_d;
        end
    end

    assign status_val   = {38'b0, empty, full, 8'(count_q), drop_cnt_q};
    assign cons_valid_o = ~empty;
    assign cons_data_o  = cons_data_q;
`else
    logic unused_cons_ready;
    assign unused_cons_ready = cons_ready_i;
    assign status_val   = 64'h0000_0000_0200_0000;
    assign cons_valid_o = 1'b0;
    assign cons_data_o  = 8'h00;
`endif

    always_comb begin
        reg_val = '0;
        case (sel)
            SEL_EXIT:    reg_val = {31'b0, exit_valid_q, exit_code_q};
            SEL_STATUS:  reg_val = status_val;
            SEL_SCRATCH: reg_val = scratch_q;
            default:     reg_val = '0;
        endcase
    end

    always_comb begin
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        scratch_d    = scratch_q;
        sel_d        = sel_q;
        mmio_rdata_d = mmio_rdata_q;
        if (wr_hit && sel == SEL_EXIT && up.be[0] && !exit_valid_q) begin
            exit_valid_d = 1'b1;
            exit_code_d  = up.wdata[31:0];
        end
        for (int b = 0; b < NBYTES; b++) begin
            if (scratch_we[b])
                scratch_d[b*8 +: 8] = up.wdata[b*8 +: 8];
        end
        // reg_val reflects pre-update state, so a read never sees its own cycle's write.
        if (rd_req) begin
            sel_d = hit;
            if (hit)
                mmio_rdata_d = reg_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
            scratch_q    <= '0;
            sel_q        <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
            scratch_q    <= scratch_d;
            sel_q        <= sel_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    assign exit_valid_o = exit_valid_q;
    assign exit_code_o  = exit_code_q;
endmodule

// File: tb/tb_tb_mem_mmio_split.sv
// Bench for tb_mem_mmio_split: directed vector table, console/reset sequences, then random
// traffic against a behavioural model of the register window and SRAM.
module tb_tb_mem_mmio_split;
    localparam logic [63:0] MMIO_BASE = 64'h0000_0000_1100_0000;
    localparam int          DEPTH     = 16;
`ifdef TB_MMIO_CONSOLE_EN
    localparam bit CONS_EN = 1'b1;
`else
    localparam bit CONS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cons_ready = 1'b0;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        cons_valid;
    logic [7:0]  cons_data;

    tb_mem_mmio_split_if #(.AW(64), .DW(64)) up_if ();
    tb_mem_mmio_split_if #(.AW(64), .DW(64)) mem_if ();

    tb_mem_mmio_split #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .MMIO_BASE(MMIO_BASE), .CONSOLE_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .up(up_if.slave), .mem(mem_if.master),
        .exit_valid_o(exit_valid), .exit_code_o(exit_code),
        .cons_valid_o(cons_valid), .cons_data_o(cons_data), .cons_ready_i(cons_ready)
    );

    always #5 clk = ~clk;

    // Bench SRAM: stores whatever the splitter passes through, one-cycle read data.
    logic [63:0] sram [logic [60:0]];
    always @(posedge clk) begin
        if (rst) begin
            mem_if.rdata <= 64'h0;
        end else if (mem_if.req) begin
            if (mem_if.we) begin
                logic [63:0] v;
                v = sram.exists(mem_if.addr[63:3]) ? sram[mem_if.addr[63:3]] : 64'h0;
                for (int b = 0; b < 8; b++)
                    if (mem_if.be[b]) v[b*8 +: 8] = mem_if.wdata[b*8 +: 8];
                sram[mem_if.addr[63:3]] = v;
            end else begin
                mem_if.rdata <= sram.exists(mem_if.addr[63:3]) ? sram[mem_if.addr[63:3]] : 64'h0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Reference model state.
    logic        m_exit_v;
    logic [31:0] m_exit_c;
    logic [63:0] m_scratch;
    logic [15:0] m_drop;
    logic [7:0]  m_q [$];
    logic [63:0] ref_mem [logic [60:0]];

    // Pending read expectation plus optional table expectation.
    logic        p_rd = 1'b0;
    logic [63:0] p_exp;
    logic        p_tbl = 1'b0;
    logic [63:0] p_tbl_exp;
    logic        tbl_en = 1'b0;
    logic [63:0] tbl_exp;
    logic [7:0]  popped [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_status();
        int n = m_q.size();
        if (!CONS_EN) return 64'h0200_0000;
        return (64'(n == 0) << 25) | (64'(n == DEPTH) << 24) | (64'(n) << 16) | 64'(m_drop);
    endfunction

    function automatic logic [63:0] m_reg_read(input logic [63:0] addr);
        case (addr[11:3])
            9'd0:    return {31'b0, m_exit_v, m_exit_c};
            9'd2:    return m_status();
            9'd3:    return m_scratch;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] m_sram_read(input logic [63:0] addr);
        return ref_mem.exists(addr[63:3]) ? ref_mem[addr[63:3]] : 64'h0;
    endfunction

    task automatic model_reset();
        m_exit_v = 1'b0; m_exit_c = '0; m_scratch = '0; m_drop = '0;
        m_q.delete();
        p_rd = 1'b0; p_tbl = 1'b0;
    endtask

    task automatic check_outputs();
        if (p_rd) chk("rdata", up_if.rdata, p_exp);
        if (p_tbl) chk("vec_rdata", up_if.rdata, p_tbl_exp);
        chk("exit_valid", exit_valid, m_exit_v);
        chk("exit_code", exit_code, m_exit_c);
        chk("cons_valid", cons_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("cons_data", cons_data, m_q[0]);
    endtask

    task automatic step(input logic req, input logic we, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] wdata, input logic ready);
        logic hit, pop, push;
        @(negedge clk);
        check_outputs();
        if (cons_ready && cons_valid) popped.push_back(cons_data);
        rst = 1'b0;
        up_if.req = req; up_if.we = we; up_if.addr = addr; up_if.be = be; up_if.wdata = wdata;
        cons_ready = ready;
        txn_no++;
        $display("txn %0d: req=%0d we=%0d addr=%h be=%h wdata=%h ready=%0d",
                 txn_no, req, we, addr, be, wdata, ready);
        #1;
        hit = (addr[63:12] == MMIO_BASE[63:12]);
        chk("mem_req", mem_if.req, req & ~hit);
        if (req && !hit) begin
            chk("mem_we", mem_if.we, we);
            chk("mem_addr", mem_if.addr, addr);
            chk("mem_be", mem_if.be, be);
            chk("mem_wdata", mem_if.wdata, wdata);
        end
        p_rd = req && !we;
        p_tbl = p_rd && tbl_en;
        p_tbl_exp = tbl_exp;
        tbl_en = 1'b0;
        if (p_rd) p_exp = hit ? m_reg_read(addr) : m_sram_read(addr);
        pop  = ready && m_q.size() != 0;
        push = CONS_EN && req && we && hit && addr[11:3] == 9'd1 && be[0];
        if (push && m_q.size() == DEPTH && !pop && m_drop != 16'hFFFF) m_drop++;
        if (pop) void'(m_q.pop_front());
        if (push && m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
        if (req && we && hit && addr[11:3] == 9'd0 && be[0] && !m_exit_v) begin
            m_exit_v = 1'b1; m_exit_c = wdata[31:0];
        end
        if (req && we) begin
            logic [63:0] v;
            v = hit ? m_scratch : m_sram_read(addr);
            for (int b = 0; b < 8; b++) if (be[b]) v[b*8 +: 8] = wdata[b*8 +: 8];
            if (hit && addr[11:3] == 9'd3) m_scratch = v;
            if (!hit) ref_mem[addr[63:3]] = v;
        end
    endtask

    task automatic do_reset(input logic with_req);
        @(negedge clk);
        check_outputs();
        rst = 1'b1; cons_ready = 1'b0;
        up_if.req = with_req; up_if.we = 1'b1; up_if.addr = MMIO_BASE;
        up_if.be = 8'hFF; up_if.wdata = 64'h77;
        txn_no++;
        $display("txn %0d: reset with_req=%0d", txn_no, with_req);
        #1;
        chk("rst_mem_req", mem_if.req, 1'b0);
        model_reset();
        @(negedge clk);
        chk("rst_exit_valid", exit_valid, 1'b0);
        chk("rst_exit_code", exit_code, 32'h0);
        chk("rst_cons_valid", cons_valid, 1'b0);
        chk("rst_cons_data", cons_data, 8'h0);
        chk("rst_rdata", up_if.rdata, 64'h0);
        rst = 1'b0; up_if.req = 1'b0;
    endtask

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [63:0] addr;
        int r;
        up_if.req = 1'b0; up_if.we = 1'b0; up_if.addr = '0; up_if.be = '0; up_if.wdata = '0;
        model_reset();

        vecs[0]  = '{1'b1, 64'h1100_0000, 8'hFF, 64'h539, 64'h0};
        vecs[1]  = '{1'b0, 64'h1100_0000, 8'hFF, 64'h0, 64'h0000_0001_0000_0539};
        vecs[2]  = '{1'b1, 64'h1100_0000, 8'hFF, 64'h1, 64'h0};
        vecs[3]  = '{1'b0, 64'h1100_0000, 8'hFF, 64'h0, 64'h0000_0001_0000_0539};
        vecs[4]  = '{1'b1, 64'h4000, 8'hFF, 64'hDEAD_BEEF, 64'h0};
        vecs[5]  = '{1'b1, 64'h4008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[6]  = '{1'b1, 64'h1100_0018, 8'h0F, 64'h1122_3344_5566_7788, 64'h0};
        vecs[7]  = '{1'b0, 64'h4000, 8'hFF, 64'h0, 64'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 64'h1100_0018, 8'hFF, 64'h0, 64'h5566_7788};
        vecs[9]  = '{1'b0, 64'h4008, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF};
        vecs[10] = '{1'b1, 64'h1100_0100, 8'hFF, 64'hFFFF, 64'h0};
        vecs[11] = '{1'b0, 64'h1100_0100, 8'hFF, 64'h0, 64'h0};
        vecs[12] = '{1'b0, 64'h1100_001F, 8'hFF, 64'h0, 64'h5566_7788};
        vecs[13] = '{1'b0, 64'h1100_0010, 8'hFF, 64'h0, 64'h0200_0000};
        vecs[14] = '{1'b0, 64'h1100_0008, 8'hFF, 64'h0, 64'h0};
        vecs[15] = '{1'b1, 64'h1100_0010, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[16] = '{1'b0, 64'h1100_0010, 8'hFF, 64'h0, 64'h0200_0000};
        vecs[17] = '{1'b1, 64'h1100_1000, 8'hFF, 64'hAA55, 64'h0};
        vecs[18] = '{1'b0, 64'h1100_1000, 8'hFF, 64'h0, 64'hAA55};

        do_reset(1'b1);

        for (int i = 0; i < 19; i++) begin
            tbl_en = !vecs[i].we;
            tbl_exp = vecs[i].exp;
            step(1'b1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, 1'b0);
        end

        // Console overflow: 18 pushes into a 16-deep FIFO with the consumer stalled.
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 64'h1100_0008, 8'h01, 64'(8'h41 + i), 1'b0);
        tbl_en = CONS_EN; tbl_exp = 64'h0110_0002;
        step(1'b1, 1'b0, 64'h1100_0010, 8'hFF, 64'h0, 1'b0);
        // Push while full in the same cycle as a pop: accepted, no drop.
        step(1'b1, 1'b1, 64'h1100_0008, 8'h01, 64'h5A, 1'b1);
        tbl_en = CONS_EN; tbl_exp = 64'h0110_0002;
        step(1'b1, 1'b0, 64'h1100_0010, 8'hFF, 64'h0, 1'b0);
        popped.delete();
        for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 1'b1);
        tbl_en = CONS_EN; tbl_exp = 64'h0200_0002;
        step(1'b1, 1'b0, 64'h1100_0010, 8'hFF, 64'h0, 1'b0);
`ifdef TB_MMIO_CONSOLE_EN
        chk("drain_count", popped.size(), 16);
        for (int i = 0; i < popped.size() && i < 16; i++)
            chk("drain_order", popped[i], (i == 15) ? 64'h5A : 64'(8'h42 + i));
`endif

        // Reset with bytes queued and EXIT latched.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 64'h1100_0008, 8'h01, 64'(8'h30 + i), 1'b0);
        step(1'b1, 1'b1, 64'h1100_0000, 8'h01, 64'h99, 1'b0);
        step(1'b1, 1'b1, 64'h1100_0018, 8'hFF, 64'hCAFE, 1'b0);
        do_reset(1'b1);
        tbl_en = 1'b1; tbl_exp = 64'h0200_0000;
        step(1'b1, 1'b0, 64'h1100_0010, 8'hFF, 64'h0, 1'b0);
        tbl_en = 1'b1; tbl_exp = 64'h0;
        step(1'b1, 1'b0, 64'h1100_0018, 8'hFF, 64'h0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 499) do_reset($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2, 3: addr = MMIO_BASE + 64'h008;
                4:          addr = MMIO_BASE + 64'h000;
                5:          addr = MMIO_BASE + 64'h010;
                6, 7:       addr = MMIO_BASE + 64'h018;
                8:          addr = MMIO_BASE + 64'(8 * $urandom_range(4, 511));
                9:          addr = MMIO_BASE + 64'h1000;
                10:         addr = MMIO_BASE - 64'h8;
                default:    addr = 64'h4000 + 64'(8 * $urandom_range(0, 7));
            endcase
            addr[2:0] = 3'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr,
                 8'($urandom_range(0, 255)), {32'($urandom), 32'($urandom)},
                 $urandom_range(0, 4) == 0);
        end
        @(negedge clk);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
